// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single-port RAM between the CPU bus path and the SPI diagnostics
// engine. The CPU owns the port until diagnostics raises halt_req; the CPU is
// then halted, and once its bus has been quiet for HALT_SETTLE cycles the
// port is granted to diagnostics. Every RAM access is sequenced here
// (chip select, write strobe, read latency) and finished with a one-cycle
// ack to the requester that owns the port. All outputs are registered.
//
// Ports
//   fpga_clk, fpga_reset          clock, async active-low reset
//   cpu_req/we/addr/wdata         CPU access request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack            CPU read data (held until the next CPU read), ack pulse
//   halt_req                      diagnostics asks for ownership (level)
//   halt, diag_grant              halt line to the CPU, diagnostics owns the port
//   diag_req/we/addr/wdata        diagnostics access request
//   diag_rdata, diag_ack          diagnostics read data, ack pulse
//   ram_cs/we/addr/wdata/rdata    single-port RAM interface
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_RUN    | CPU owns the port, halt low
// S_SETTLE | halt high, CPU still serviced, counting quiet cycles
// S_HALTED | halt high, diagnostics owns the port
// S_ACC_WR | one-cycle write strobe
// S_ACC_RD | chip select held RD_LAT cycles, data captured on the last
// S_ACK    | one-cycle ack to the recorded owner
module ram_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RD_LAT      = 2,
    parameter int HALT_SETTLE = 4
) (
    input  logic              fpga_clk,
    input  logic              fpga_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              halt_req,
    output logic              halt,
    output logic              diag_grant,
    input  logic              diag_req,
    input  logic              diag_we,
    input  logic [ADDR_W-1:0] diag_addr,
    input  logic [DATA_W-1:0] diag_wdata,
    output logic [DATA_W-1:0] diag_rdata,
    output logic              diag_ack,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_RUN, S_SETTLE, S_HALTED, S_ACC_WR, S_ACC_RD, S_ACK
    } state_t;

    localparam logic [7:0] SETTLE_TC = 8'(HALT_SETTLE);
    localparam logic [2:0] LAT_LOAD  = 3'(RD_LAT - 1);

    state_t            state, state_nxt;
    state_t            ret_state, ret_nxt;   // owner-idle state to resume after the access
    state_t            idle_nxt;
    logic              owner_diag, owner_nxt;
    logic [7:0]        settle_cnt, settle_nxt;
    logic [2:0]        lat_cnt, lat_nxt;     // read latency down-counter
    logic              start_acc, start_we, rd_done;
    logic [ADDR_W-1:0] start_addr;
    logic [DATA_W-1:0] start_wdata;
    logic              in_acc_nxt;
    logic              ram_cs_d, ram_we_d, cpu_ack_d, diag_ack_d, halt_d, diag_grant_d;

    always_ff @(posedge fpga_clk or negedge fpga_reset) begin
        if (!fpga_reset) begin
            state      <= S_RUN;
            ret_state  <= S_RUN;
            owner_diag <= 1'b0;
            settle_cnt <= '0;
            lat_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            ret_state  <= ret_nxt;
            owner_diag <= owner_nxt;
            settle_cnt <= settle_nxt;
            lat_cnt    <= lat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ret_nxt     = ret_state;
        owner_nxt   = owner_diag;
        settle_nxt  = settle_cnt;
        lat_nxt     = lat_cnt;
        start_acc   = 1'b0;
        start_we    = cpu_we;
        start_addr  = cpu_addr;
        start_wdata = cpu_wdata;
        rd_done     = 1'b0;
        case (state)
            S_RUN: begin
                if (cpu_req) begin
                    start_acc = 1'b1;
                    owner_nxt = 1'b0;
                end else if (halt_req) begin
                    state_nxt  = S_SETTLE;
                    settle_nxt = '0;
                end
            end
            S_SETTLE: begin
                if (cpu_req) begin
                    start_acc  = 1'b1;
                    owner_nxt  = 1'b0;
                    settle_nxt = '0;
                end else if (!halt_req) begin
                    state_nxt = S_RUN;
                end else begin
                    if (settle_cnt != SETTLE_TC) settle_nxt = settle_cnt + 8'd1;
                    // grant on the cycle the count reaches its terminal value
                    if (settle_nxt == SETTLE_TC) state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (diag_req) begin
                    start_acc   = 1'b1;
                    owner_nxt   = 1'b1;
                    start_we    = diag_we;
                    start_addr  = diag_addr;
                    start_wdata = diag_wdata;
                end else if (!halt_req) begin
                    state_nxt = S_RUN;
                end
            end
            S_ACC_WR: state_nxt = S_ACK;
            S_ACC_RD: begin
                if (lat_cnt == 3'd0) begin
                    rd_done   = 1'b1;
                    state_nxt = S_ACK;
                end else begin
                    lat_nxt = lat_cnt - 3'd1;
                end
            end
            S_ACK: begin
                // halt_req is re-evaluated on leaving the ack, so a drop during
                // the access releases halt/grant right after the ack cycle
                settle_nxt = '0;
                if (!halt_req)                state_nxt = S_RUN;
                else if (ret_state == S_RUN)  state_nxt = S_SETTLE;
                else                          state_nxt = ret_state;
            end
            default: state_nxt = S_RUN;
        endcase
        if (start_acc) begin
            ret_nxt   = state;
            state_nxt = start_we ? S_ACC_WR : S_ACC_RD;
            lat_nxt   = LAT_LOAD;
        end
    end

    always_comb begin
        in_acc_nxt   = (state_nxt == S_ACC_WR) || (state_nxt == S_ACC_RD) || (state_nxt == S_ACK);
        idle_nxt     = in_acc_nxt ? ret_nxt : state_nxt;
        ram_cs_d     = (state_nxt == S_ACC_WR) || (state_nxt == S_ACC_RD);
        ram_we_d     = state_nxt == S_ACC_WR;
        cpu_ack_d    = (state_nxt == S_ACK) && !owner_nxt;
        diag_ack_d   = (state_nxt == S_ACK) && owner_nxt;
        halt_d       = idle_nxt != S_RUN;
        diag_grant_d = idle_nxt == S_HALTED;
    end

    always_ff @(posedge fpga_clk or negedge fpga_reset) begin
        if (!fpga_reset) begin
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            cpu_ack    <= 1'b0;
            diag_ack   <= 1'b0;
            halt       <= 1'b0;
            diag_grant <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_rdata  <= '0;
            diag_rdata <= '0;
        end else begin
            ram_cs     <= ram_cs_d;
            ram_we     <= ram_we_d;
            cpu_ack    <= cpu_ack_d;
            diag_ack   <= diag_ack_d;
            halt       <= halt_d;
            diag_grant <= diag_grant_d;
            if (start_acc) ram_addr <= start_addr;
            if (start_acc && start_we) ram_wdata <= start_wdata;
            if (rd_done) begin
                if (owner_diag) diag_rdata <= ram_rdata;
                else            cpu_rdata  <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (RD_LAT=2 and RD_LAT=3) share one
// input stream; each drives its own behavioural RAM and is compared every
// cycle with an access-level reference model, plus directed checks.
module tb_ram_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int HS = 4;

    logic          fpga_clk = 1'b0;
    logic          fpga_reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          halt_req = 1'b0;
    logic          diag_req = 1'b0, diag_we = 1'b0;
    logic [AW-1:0] diag_addr = '0;
    logic [DW-1:0] diag_wdata = '0;

    logic [DW-1:0] cpu_rdata_o [2];
    logic [DW-1:0] diag_rdata_o [2];
    logic          cpu_ack_o [2], diag_ack_o [2], halt_o [2], diag_grant_o [2];
    logic          ram_cs_o [2], ram_we_o [2];
    logic [AW-1:0] ram_addr_o [2];
    logic [DW-1:0] ram_wdata_o [2];
    logic [DW-1:0] ram_rdata_i [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 fpga_clk = ~fpga_clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .HALT_SETTLE(HS)) u_dut0 (
        .fpga_clk(fpga_clk), .fpga_reset(fpga_reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_o[0]), .cpu_ack(cpu_ack_o[0]),
        .halt_req(halt_req), .halt(halt_o[0]), .diag_grant(diag_grant_o[0]),
        .diag_req(diag_req), .diag_we(diag_we), .diag_addr(diag_addr), .diag_wdata(diag_wdata),
        .diag_rdata(diag_rdata_o[0]), .diag_ack(diag_ack_o[0]),
        .ram_cs(ram_cs_o[0]), .ram_we(ram_we_o[0]), .ram_addr(ram_addr_o[0]),
        .ram_wdata(ram_wdata_o[0]), .ram_rdata(ram_rdata_i[0])
    );

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .HALT_SETTLE(HS)) u_dut1 (
        .fpga_clk(fpga_clk), .fpga_reset(fpga_reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_o[1]), .cpu_ack(cpu_ack_o[1]),
        .halt_req(halt_req), .halt(halt_o[1]), .diag_grant(diag_grant_o[1]),
        .diag_req(diag_req), .diag_we(diag_we), .diag_addr(diag_addr), .diag_wdata(diag_wdata),
        .diag_rdata(diag_rdata_o[1]), .diag_ack(diag_ack_o[1]),
        .ram_cs(ram_cs_o[1]), .ram_we(ram_we_o[1]), .ram_addr(ram_addr_o[1]),
        .ram_wdata(ram_wdata_o[1]), .ram_rdata(ram_rdata_i[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    // RAM models: data is only valid once chip select has been held for the
    // instance's read latency; before that the bus carries inverted data.
    logic [DW-1:0] mem0 [65536];
    logic [DW-1:0] mem1 [65536];
    int cs_cnt0 = 0, cs_cnt1 = 0;

    always @(posedge fpga_clk) begin
        if (ram_cs_o[0] && ram_we_o[0]) mem0[ram_addr_o[0]] <= ram_wdata_o[0];
        cs_cnt0 <= ram_cs_o[0] ? cs_cnt0 + 1 : 0;
    end
    always @(posedge fpga_clk) begin
        if (ram_cs_o[1] && ram_we_o[1]) mem1[ram_addr_o[1]] <= ram_wdata_o[1];
        cs_cnt1 <= ram_cs_o[1] ? cs_cnt1 + 1 : 0;
    end
    assign ram_rdata_i[0] = (cs_cnt0 >= lat_of(0) - 1) ? mem0[ram_addr_o[0]] : ~mem0[ram_addr_o[0]];
    assign ram_rdata_i[1] = (cs_cnt1 >= lat_of(1) - 1) ? mem1[ram_addr_o[1]] : ~mem1[ram_addr_o[1]];

    // Reference model: mode 0=CPU runs, 1=settling, 2=diagnostics granted.
    // An access is a count of chip-select cycles followed by one ack cycle.
    int            m_mode [2];
    int            m_left [2];
    int            m_quiet [2];
    bit            m_busy [2], m_diag [2], m_we [2];
    logic [AW-1:0] m_addr [2];
    logic [AW-1:0] e_addr [2];
    logic [DW-1:0] e_wdata [2], e_crd [2], e_drd [2];
    logic [DW-1:0] shadow [2][65536];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_mode[k] = 0; m_left[k] = 0; m_quiet[k] = 0;
        m_busy[k] = 0; m_diag[k] = 0; m_we[k] = 0; m_addr[k] = '0;
        e_addr[k] = '0; e_wdata[k] = '0; e_crd[k] = '0; e_drd[k] = '0;
    endtask

    task automatic model_start(input int k, input bit d, input bit we,
                               input logic [AW-1:0] a, input logic [DW-1:0] wd);
        m_busy[k] = 1; m_diag[k] = d; m_we[k] = we; m_addr[k] = a;
        m_left[k] = we ? 1 : lat_of(k);
        e_addr[k] = a;
        if (we) begin
            e_wdata[k] = wd;
            shadow[k][a] = wd;
        end
    endtask

    task automatic model_step(input int k);
        if (!fpga_reset) begin
            model_reset(k);
            return;
        end
        if (m_busy[k]) begin
            if (m_left[k] > 0) begin
                m_left[k]--;
                if (m_left[k] == 0 && !m_we[k]) begin
                    if (m_diag[k]) e_drd[k] = shadow[k][m_addr[k]];
                    else           e_crd[k] = shadow[k][m_addr[k]];
                end
            end else begin
                m_busy[k] = 0;
                m_quiet[k] = 0;
                if (!halt_req)          m_mode[k] = 0;
                else if (m_mode[k] == 0) m_mode[k] = 1;
            end
        end else begin
            case (m_mode[k])
                0: begin
                    if (cpu_req) model_start(k, 0, cpu_we, cpu_addr, cpu_wdata);
                    else if (halt_req) begin m_mode[k] = 1; m_quiet[k] = 0; end
                end
                1: begin
                    if (cpu_req) begin
                        model_start(k, 0, cpu_we, cpu_addr, cpu_wdata);
                        m_quiet[k] = 0;
                    end else if (!halt_req) m_mode[k] = 0;
                    else begin
                        m_quiet[k]++;
                        if (m_quiet[k] >= HS) m_mode[k] = 2;
                    end
                end
                default: begin
                    if (diag_req) model_start(k, 1, diag_we, diag_addr, diag_wdata);
                    else if (!halt_req) m_mode[k] = 0;
                end
            endcase
        end
    endtask

    task automatic compare_all(input int k);
        bit e_cs;
        bit e_ack;
        e_cs  = m_busy[k] && m_left[k] > 0;
        e_ack = m_busy[k] && m_left[k] == 0;
        chk($sformatf("ctl%0d", k),
            64'({ram_cs_o[k], ram_we_o[k], cpu_ack_o[k], diag_ack_o[k], halt_o[k], diag_grant_o[k]}),
            64'({e_cs, e_cs && m_we[k], e_ack && !m_diag[k], e_ack && m_diag[k],
                 m_mode[k] != 0, m_mode[k] == 2}));
        chk($sformatf("dat%0d", k),
            64'({ram_addr_o[k], ram_wdata_o[k], cpu_rdata_o[k], diag_rdata_o[k]}),
            64'({e_addr[k], e_wdata[k], e_crd[k], e_drd[k]}));
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        model_step(0);
        model_step(1);
        @(negedge fpga_clk);
        compare_all(0);
        compare_all(1);
    endtask

    // Issue one access and wait (bounded) for instance 0's ack; lat counts
    // edges from the sampling edge to the ack cycle.
    task automatic do_acc(input bit d, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output int lat);
        if (d) begin diag_req = 1; diag_we = we; diag_addr = a; diag_wdata = wd; end
        else   begin cpu_req = 1;  cpu_we = we;  cpu_addr = a;  cpu_wdata = wd;  end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(d ? diag_ack_o[0] : cpu_ack_o[0]) && lat < 20);
        cpu_req = 0;
        diag_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n, cnt;
        for (int a = 0; a < 65536; a++) begin
            shadow[0][a] = '0;
            shadow[1][a] = '0;
        end
        model_reset(0);
        model_reset(1);

        repeat (3) tick();
        chk("reset_outputs", 64'({cpu_ack_o[0], halt_o[0], diag_grant_o[0], ram_cs_o[0], cpu_rdata_o[0]}), 64'(0));
        fpga_reset = 1;
        tick();

        // CPU write then read back
        do_acc(0, 1, 16'h1234, 8'hA5, lat);
        chk("cpu_wr_lat", 64'(lat), 64'(2));
        repeat (2) tick();
        do_acc(0, 0, 16'h1234, 8'h00, lat);
        chk("cpu_rd_lat", 64'(lat), 64'(3));
        chk("cpu_rd_data", 64'(cpu_rdata_o[0]), 64'(8'hA5));
        repeat (2) tick();

        // halt with CPU idle, grant after HS quiet cycles
        halt_req = 1;
        tick();
        chk("halt_rise", 64'({halt_o[0], diag_grant_o[0]}), 64'(2'b10));
        n = 0;
        while (!diag_grant_o[0] && n < 50) begin tick(); n++; end
        chk("grant_lat", 64'(n), 64'(HS));
        do_acc(1, 1, 16'h0000, 8'h3C, lat);
        chk("diag_wr_lat", 64'(lat), 64'(2));
        repeat (2) tick();
        do_acc(1, 0, 16'h0000, 8'h00, lat);
        chk("diag_rd_data", 64'(diag_rdata_o[0]), 64'(8'h3C));
        repeat (2) tick();
        halt_req = 0;
        tick();
        chk("halt_release", 64'({halt_o[0], diag_grant_o[0]}), 64'(0));
        tick();

        // halt_req with CPU traffic every third cycle: first access rides on
        // the simultaneous halt_req rise, each later one restarts the count
        halt_req = 1;
        for (int i = 0; i < 3; i++) begin
            do_acc(0, 1, 16'h0100 + 16'(i), 8'h50 + 8'(i), lat);
            chk("settle_wr_lat", 64'(lat), 64'(2));
            chk("settle_no_grant", 64'(diag_grant_o[0]), 64'(0));
            if (i < 2) tick();
        end
        // from the ack cycle: HS quiet SETTLE cycles, then the grant cycle
        n = 0;
        while (!diag_grant_o[0] && n < 50) begin tick(); n++; end
        chk("settle_restart", 64'(n), 64'(HS + 1));

        // CPU requests ignored while halted
        cnt = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'hEE;
        repeat (4) begin
            tick();
            cnt += int'(cpu_ack_o[0]) + int'(ram_cs_o[0]) + int'(cpu_ack_o[1]) + int'(ram_cs_o[1]);
        end
        cpu_req = 0;
        chk("halted_cpu_ignored", 64'(cnt), 64'(0));
        halt_req = 0;
        tick();
        // diagnostics requests ignored while not granted
        cnt = 0;
        diag_req = 1; diag_we = 1; diag_addr = 16'h0300; diag_wdata = 8'h77;
        repeat (4) begin
            tick();
            cnt += int'(diag_ack_o[0]) + int'(ram_cs_o[0]) + int'(diag_ack_o[1]) + int'(ram_cs_o[1]);
        end
        diag_req = 0;
        chk("run_diag_ignored", 64'(cnt), 64'(0));

        // drop halt_req mid diag read on the RD_LAT=3 instance
        halt_req = 1;
        tick();
        n = 0;
        while (!diag_grant_o[1] && n < 50) begin tick(); n++; end
        chk("rl3_grant_lat", 64'(n), 64'(HS));
        diag_req = 1; diag_we = 0; diag_addr = 16'h0000;
        tick();
        tick();
        halt_req = 0;
        n = 2;
        while (!diag_ack_o[1] && n < 20) begin tick(); n++; end
        chk("rl3_ack_lat", 64'(n), 64'(4));
        chk("rl3_data", 64'(diag_rdata_o[1]), 64'(8'h3C));
        chk("rl3_halt_in_ack", 64'({halt_o[1], diag_grant_o[1]}), 64'(2'b11));
        diag_req = 0;
        tick();
        chk("rl3_release", 64'({halt_o[1], diag_grant_o[1]}), 64'(0));
        repeat (2) tick();

        // asynchronous reset in the middle of a read
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        tick();
        chk("rd_cs_before_rst", 64'({ram_cs_o[0], ram_cs_o[1]}), 64'(2'b11));
        #2 fpga_reset = 0;
        #1;
        model_reset(0);
        model_reset(1);
        chk("rst_async", 64'({ram_cs_o[0], ram_we_o[0], halt_o[0], diag_grant_o[0], cpu_ack_o[0], diag_ack_o[0],
                              ram_cs_o[1], ram_we_o[1], halt_o[1], diag_grant_o[1], cpu_ack_o[1], diag_ack_o[1]}),
            64'(0));
        cpu_req = 0;
        tick();
        fpga_reset = 1;
        tick();
        do_acc(0, 1, 16'h0042, 8'h99, lat);
        chk("post_rst_wr_lat", 64'(lat), 64'(2));
        repeat (2) tick();
        do_acc(0, 0, 16'h0042, 8'h00, lat);
        chk("post_rst_rd_lat", 64'(lat), 64'(3));
        chk("post_rst_rd_data", 64'(cpu_rdata_o[0]), 64'(8'h99));
        repeat (2) tick();

        // random traffic against the model
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
            if (!cpu_req || cpu_ack_o[0] || $urandom_range(0, 7) == 0) begin
                cpu_req   = ($urandom_range(0, 2) == 0);
                cpu_we    = 1'($urandom);
                cpu_addr  = 16'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
            if (!diag_req || diag_ack_o[0] || $urandom_range(0, 7) == 0) begin
                diag_req   = ($urandom_range(0, 2) == 0);
                diag_we    = 1'($urandom);
                diag_addr  = 16'($urandom_range(0, 15));
                diag_wdata = 8'($urandom);
            end
            tick();
        end
        cpu_req = 0;
        diag_req = 0;
        halt_req = 0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single-port replacement RAM between the CPU bus path and the SPI diagnostics engine. The CPU owns the port by default. The diagnostics engine requests a halt, and the arbiter asserts halt to the CPU. After the CPU bus has been quiet for a settle window, the arbiter hands the port to the diagnostics engine. The arbiter sequences every RAM access (chip select, write strobe, read latency) and returns one-cycle acknowledges to the owning requester.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
RD_LAT, 2, cycles ram_cs is held for a read before ram_rdata is captured (legal range 1..7)
HALT_SETTLE, 4, consecutive quiet cycles with halt high before the diagnostics engine is granted (legal range 1..255)

Ports:
fpga_clk  in  1  system clock
fpga_reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1=write, 0=read; valid while cpu_req
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid in the cpu_ack cycle
cpu_ack  out  1  one-cycle access-complete pulse
halt_req  in  1  diagnostics requests ownership (level)
halt  out  1  halt line to the CPU
diag_grant  out  1  diagnostics owns the RAM port
diag_req  in  1  diagnostics access request, level, held until diag_ack
diag_we  in  1  write select
diag_addr  in  ADDR_W  diagnostics address
diag_wdata  in  DATA_W  diagnostics write data
diag_rdata  out  DATA_W  diagnostics read data, valid in the diag_ack cycle
diag_ack  out  1  one-cycle pulse
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, fpga_reset=0): every output is 0, the state is RUN, and the settle counter is 0. Reset asserted mid-access drops ram_cs and ram_we immediately. No ack is produced for the aborted access.
- All outputs are registered.
- States:
  - RUN: CPU owns the port; halt=0, diag_grant=0.
  - SETTLE: halt=1; CPU is still serviced; diag_grant=0.
  - HALTED: halt=1, diag_grant=1.
  - ACC_WR and ACC_RD: access in progress; the owner is recorded in an internal flag.
  - ACK: single cycle with the owner's ack=1.
- Access sequencing, with request sampled high at cycle N in RAM owner-idle (RUN, SETTLE or HALTED):
  - Latch addr, wdata and we at N.
  - Write: cycle N+1 has ram_cs=1, ram_we=1. Cycle N+2 has ram_cs=0, ram_we=0 and ack=1.
  - Read: ram_cs=1 and ram_we=0 for cycles N+1..N+RD_LAT. ram_rdata is captured at the end of N+RD_LAT into the owner's rdata. Cycle N+RD_LAT+1 has ram_cs=0 and ack=1.
  - The rdata output holds its value until the next read by the same requester.
  - After ACK, return to the owner-idle state. The next request is sampled no earlier than ack+1.
- Non-owner requests: no ack and no RAM activity. diag_req outside HALTED is ignored. cpu_req in HALTED is ignored.
- RUN with halt_req=1: go to SETTLE and assert halt next cycle. The counter is cleared.
- SETTLE counter:
  - Increments each cycle in SETTLE with cpu_req=0.
  - Clears on any cycle with cpu_req=1 (that access is still serviced, with return to SETTLE).
  - At count==HALT_SETTLE: go to HALTED and set diag_grant=1.
- SETTLE with halt_req=0: return to RUN and deassert halt next cycle.
- HALTED with halt_req=0 and no access in progress: return to RUN with halt=0 and diag_grant=0 the same edge.
- halt_req dropped during ACC_*/ACK: the access completes with an ack, then the block evaluates halt_req in owner-idle.
- A simultaneous halt_req rise and cpu_req in RUN: the CPU access is taken first. SETTLE is entered after its ACK.
- Counter width is 8 bits and saturates at HALT_SETTLE.
- ram_wdata is only meaningful when ram_we=1. It is held at the last written value otherwise.

Test Plan:
- Reset with default parameters: CPU write 0x1234<-0xA5. Required: ram_cs=1 and ram_we=1 exactly one cycle later, cpu_ack two cycles after the request is sampled, then a CPU read of 0x1234 returns 0xA5 with cpu_ack at N+3.
- Assert halt_req with the CPU idle. Required: halt=1 at the next cycle, diag_grant=1 exactly HALT_SETTLE(4) cycles later. A diag write 0x0000<-0x3C followed by a diag read returns 0x3C.
- Assert halt_req while issuing cpu_req every 3rd cycle for 10 cycles. Required: every CPU access is acked, the counter restarts after each one, and diag_grant rises only 4 quiet cycles after the last ack.
- Pulse diag_req with halt_req=0, and cpu_req in HALTED. Required: no ack, and ram_cs stays 0.
- Drop halt_req mid diag read, with RD_LAT=3 variant. Required: diag_ack still pulses with the correct data, then halt=0 and diag_grant=0 on the following edge.
- Assert fpga_reset=0 during an ACC_RD cycle. Required: ram_cs, halt, diag_grant and the acks go to 0 asynchronously. After release the state is RUN and a fresh CPU access completes normally.
